// File: rtl/core_sequencer.sv
// Multi-cycle RV32I sequencer: fetch, decode, execute, memory and writeback phase control.
// Optional macro PERF_CNT_EN enables the retired-instruction and active-cycle counters.
module core_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RUN,
    input  logic             IMEM_RDY,
    input  logic [31:0]      IMEM_INST,
    input  logic             DMEM_RDY,
    input  logic             BR_TAKEN,
    output logic             IMEM_REQ,
    output logic [31:0]      INST_REG,
    output logic             INST_ENB,
    output logic             ALU_ENB,
    output logic             DMEM_REQ,
    output logic             DMEM_WE,
    output logic             REG_WE,
    output logic             PC_CLK,
    output logic             PC_SEL,
    output logic [3:0]       STATE,
    output logic             HALTED,
    output logic             FAULT,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] RETIRED_CNT,
    output logic [CNT_W-1:0] CYCLE_CNT
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_MEM       = 4'd4,
        S_WRITEBACK = 4'd5,
        S_HALT      = 4'd6,
        S_FAULT     = 4'd7
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [7:0] TO_LIMIT  = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        br_q, br_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode;
    logic        opc_legal;
    logic        no_reg_write;

    assign opcode = inst_q[6:0];

    always_comb begin
        opc_legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: opc_legal = 1'b1;
            default: opc_legal = 1'b0;
        endcase
    end

    assign no_reg_write = (opcode == OP_BRANCH) || (opcode == OP_STORE) ||
                          (opcode == OP_FENCE) || (inst_q[11:7] == 5'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            inst_q    <= '0;
            to_cnt_q  <= '0;
            br_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            to_cnt_q  <= to_cnt_d;
            br_q      <= br_d;
            illegal_q <= illegal_d;
        end
    end

    // The wait counter only survives while the state holds, so every entry to FETCH/MEM starts at 0.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        to_cnt_d  = '0;
        br_d      = br_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: if (RUN) state_d = S_FETCH;
            S_FETCH: begin
                if (IMEM_RDY) begin
                    inst_d  = IMEM_INST;
                    state_d = S_DECODE;
                end else if (to_cnt_q == TO_LIMIT) begin
                    state_d   = S_FAULT;
                    illegal_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (!opc_legal) begin
                    state_d   = S_FAULT;
                    illegal_d = 1'b1;
                end else if (opcode == OP_SYSTEM && inst_q[14:12] == 3'b000) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                br_d    = BR_TAKEN;
                state_d = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
                if (DMEM_RDY) begin
                    state_d = S_WRITEBACK;
                end else if (to_cnt_q == TO_LIMIT) begin
                    state_d   = S_FAULT;
                    illegal_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            S_WRITEBACK: state_d = RUN ? S_FETCH : S_IDLE;
            S_HALT:      state_d = S_HALT;
            S_FAULT:     state_d = S_FAULT;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        IMEM_REQ = 1'b0;
        INST_ENB = 1'b0;
        ALU_ENB  = 1'b0;
        DMEM_REQ = 1'b0;
        DMEM_WE  = 1'b0;
        REG_WE   = 1'b0;
        PC_CLK   = 1'b0;
        PC_SEL   = 1'b0;
        HALTED   = 1'b0;
        FAULT    = 1'b0;
        ILLEGAL  = 1'b0;
        case (state_q)
            S_FETCH:   IMEM_REQ = 1'b1;
            S_DECODE:  INST_ENB = 1'b1;
            S_EXECUTE: ALU_ENB  = 1'b1;
            S_MEM: begin
                DMEM_REQ = 1'b1;
                DMEM_WE  = (opcode == OP_STORE);
            end
            S_WRITEBACK: begin
                PC_CLK = 1'b1;
                REG_WE = !no_reg_write;
                PC_SEL = br_q;
            end
            S_HALT:  HALTED = 1'b1;
            S_FAULT: begin
                FAULT   = 1'b1;
                ILLEGAL = illegal_q;
            end
            default: ;
        endcase
    end

    assign STATE    = state_q;
    assign INST_REG = inst_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] retired_q, cycle_q;
    logic             active;

    assign active = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                    (state_q == S_MEM) || (state_q == S_WRITEBACK);

    always_ff @(posedge CLK) begin
        if (RST) begin
            retired_q <= '0;
            cycle_q   <= '0;
        end else begin
            if (state_q == S_WRITEBACK) retired_q <= retired_q + CNT_W'(1);
            if (active)                 cycle_q   <= cycle_q + CNT_W'(1);
        end
    end

    assign RETIRED_CNT = retired_q;
    assign CYCLE_CNT   = cycle_q;
`else
    assign RETIRED_CNT = '0;
    assign CYCLE_CNT   = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: one table of single-instruction runs plus
// hand sequences for reset, reset during MEM and back-to-back issue.
module tb_core_sequencer;

    localparam int CNT_W = 32;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             CLK, RST, RUN, IMEM_RDY, DMEM_RDY, BR_TAKEN;
    logic [31:0]      IMEM_INST, INST_REG;
    logic             IMEM_REQ, INST_ENB, ALU_ENB, DMEM_REQ, DMEM_WE, REG_WE;
    logic             PC_CLK, PC_SEL, HALTED, FAULT, ILLEGAL;
    logic [3:0]       STATE;
    logic [CNT_W-1:0] RETIRED_CNT, CYCLE_CNT;
    logic [10:0]      strobes;

    core_sequencer #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .IMEM_RDY(IMEM_RDY), .IMEM_INST(IMEM_INST),
        .DMEM_RDY(DMEM_RDY), .BR_TAKEN(BR_TAKEN), .IMEM_REQ(IMEM_REQ), .INST_REG(INST_REG),
        .INST_ENB(INST_ENB), .ALU_ENB(ALU_ENB), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
        .REG_WE(REG_WE), .PC_CLK(PC_CLK), .PC_SEL(PC_SEL), .STATE(STATE), .HALTED(HALTED),
        .FAULT(FAULT), .ILLEGAL(ILLEGAL), .RETIRED_CNT(RETIRED_CNT), .CYCLE_CNT(CYCLE_CNT)
    );

    assign strobes = {IMEM_REQ, INST_ENB, ALU_ENB, DMEM_REQ, DMEM_WE, REG_WE,
                      PC_CLK, PC_SEL, HALTED, FAULT, ILLEGAL};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; RUN = 1'b0; IMEM_RDY = 1'b0; DMEM_RDY = 1'b0; BR_TAKEN = 1'b0;
        step();
        RST = 1'b0;
    endtask

    typedef struct {
        logic [31:0] inst;
        bit          imem_ok;
        int          dwait;
        bit          br;
        int          act;    // cycles spent in FETCH..WRITEBACK
        int          pcc;    // PC_CLK pulses
        int          rwe;    // REG_WE cycles
        int          psel;   // PC_SEL seen in WRITEBACK
        int          dreq;
        int          dwe;
        int          ienb;
        int          ireq;
        logic [3:0]  fstate;
        bit          ill;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // inst imem dwait br | act pcc rwe psel dreq dwe ienb ireq fstate ill
        vecs[0]  = '{32'h00500093, 1, 0,   0, 4,  1, 1, 0, 0,  0,  1, 1,  4'd0, 0}; // addi x1
        vecs[1]  = '{32'h0000A103, 1, 3,   0, 8,  1, 1, 0, 4,  0,  1, 1,  4'd0, 0}; // lw, 3 waits
        vecs[2]  = '{32'h0020A023, 1, 0,   0, 5,  1, 0, 0, 1,  1,  1, 1,  4'd0, 0}; // sw
        vecs[3]  = '{32'h00000463, 1, 0,   1, 4,  1, 0, 1, 0,  0,  1, 1,  4'd0, 0}; // beq taken
        vecs[4]  = '{32'h00000013, 1, 0,   0, 4,  1, 0, 0, 0,  0,  1, 1,  4'd0, 0}; // rd = x0
        vecs[5]  = '{32'h123450B7, 1, 0,   1, 4,  1, 1, 1, 0,  0,  1, 1,  4'd0, 0}; // lui
        vecs[6]  = '{32'h0000000F, 1, 0,   0, 4,  1, 0, 0, 0,  0,  1, 1,  4'd0, 0}; // fence
        vecs[7]  = '{32'h000010F3, 1, 0,   0, 4,  1, 1, 0, 0,  0,  1, 1,  4'd0, 0}; // csrrw x1
        vecs[8]  = '{32'h000080E7, 1, 0,   1, 4,  1, 1, 1, 0,  0,  1, 1,  4'd0, 0}; // jalr
        vecs[9]  = '{32'h0000007F, 1, 0,   0, 2,  0, 0, 0, 0,  0,  1, 1,  4'd7, 1}; // illegal
        vecs[10] = '{32'h0020A023, 1, 100, 0, 19, 0, 0, 0, 16, 16, 1, 1,  4'd7, 0}; // sw timeout
        vecs[11] = '{32'h00500093, 0, 0,   0, 16, 0, 0, 0, 0,  0,  0, 16, 4'd7, 0}; // fetch timeout
        vecs[12] = '{32'h00100073, 1, 0,   0, 2,  0, 0, 0, 0,  0,  1, 1,  4'd6, 0}; // ebreak
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int act, pcc, rwe, psel, dreq, dwe, ienb, ireq, pc_at, mem_k;
        int pulses, first_at, second_at, found;
        string p;

        IMEM_INST = 32'h0;
        do_reset();
        chk("reset_state", 32'(STATE), 32'd0);
        chk("reset_strobes", 32'(strobes), 32'd0);
        chk("reset_inst_reg", INST_REG, 32'h0);
        chk("reset_retired", RETIRED_CNT, 32'd0);
        chk("reset_cycles", CYCLE_CNT, 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_reset();
            IMEM_INST = vecs[i].inst;
            IMEM_RDY  = vecs[i].imem_ok;
            BR_TAKEN  = vecs[i].br;
            RUN       = 1'b1;
            act = 0; pcc = 0; rwe = 0; psel = 0; dreq = 0; dwe = 0;
            ienb = 0; ireq = 0; pc_at = 0; mem_k = 0;
            // 40 cycles covers the longest run and also shows HALT/FAULT holding with RUN high.
            for (int c = 0; c < 40; c++) begin
                step();
                if (STATE >= 4'd1 && STATE <= 4'd5) act++;
                if (PC_CLK) begin pcc++; pc_at = act; end
                if (REG_WE) rwe++;
                if (STATE == 4'd5) psel = int'(PC_SEL);
                if (DMEM_REQ) dreq++;
                if (DMEM_WE) dwe++;
                if (INST_ENB) ienb++;
                if (IMEM_REQ) ireq++;
                if (STATE == 4'd3) RUN = 1'b0;
                if (STATE == 4'd4) begin
                    mem_k++;
                    DMEM_RDY = (mem_k > vecs[i].dwait);
                end else begin
                    DMEM_RDY = 1'b0;
                end
            end
            p = $sformatf("v%0d_", i);
            chk({p, "active_cycles"}, 32'(act), 32'(vecs[i].act));
            chk({p, "pc_clk_pulses"}, 32'(pcc), 32'(vecs[i].pcc));
            chk({p, "pc_clk_position"}, 32'(pc_at), 32'(vecs[i].pcc != 0 ? vecs[i].act : 0));
            chk({p, "reg_we_cycles"}, 32'(rwe), 32'(vecs[i].rwe));
            chk({p, "pc_sel"}, 32'(psel), 32'(vecs[i].psel));
            chk({p, "dmem_req_cycles"}, 32'(dreq), 32'(vecs[i].dreq));
            chk({p, "dmem_we_cycles"}, 32'(dwe), 32'(vecs[i].dwe));
            chk({p, "inst_enb_cycles"}, 32'(ienb), 32'(vecs[i].ienb));
            chk({p, "imem_req_cycles"}, 32'(ireq), 32'(vecs[i].ireq));
            chk({p, "final_state"}, 32'(STATE), 32'(vecs[i].fstate));
            chk({p, "halted"}, 32'(HALTED), 32'(vecs[i].fstate == 4'd6));
            chk({p, "fault"}, 32'(FAULT), 32'(vecs[i].fstate == 4'd7));
            chk({p, "illegal"}, 32'(ILLEGAL), 32'(vecs[i].ill));
            chk({p, "imem_req_end"}, 32'(IMEM_REQ), 32'd0);
            chk({p, "inst_reg"}, INST_REG, vecs[i].imem_ok ? vecs[i].inst : 32'h0);
            chk({p, "retired_cnt"}, RETIRED_CNT, PERF ? 32'(vecs[i].pcc) : 32'd0);
            chk({p, "cycle_cnt"}, CYCLE_CNT, PERF ? 32'(vecs[i].act) : 32'd0);
        end

        // The table ends parked in HALT after ebreak; one reset cycle must clear everything.
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("halt_reset_state", 32'(STATE), 32'd0);
        chk("halt_reset_strobes", 32'(strobes), 32'd0);
        chk("halt_reset_inst_reg", INST_REG, 32'h0);
        chk("halt_reset_retired", RETIRED_CNT, 32'd0);

        // Reset while a store waits in MEM: no PC_CLK or REG_WE afterwards.
        do_reset();
        IMEM_INST = 32'h0020A023; IMEM_RDY = 1'b1; RUN = 1'b1;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            step();
            if (STATE == 4'd4) found = 1;
        end
        chk("rst_mem_reached_mem", 32'(found), 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0; RUN = 1'b0;
        chk("rst_mem_state", 32'(STATE), 32'd0);
        chk("rst_mem_strobes", 32'(strobes), 32'd0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (PC_CLK || REG_WE) pulses++;
        end
        chk("rst_mem_no_pulses", 32'(pulses), 32'd0);
        chk("rst_mem_idle", 32'(STATE), 32'd0);

        // Back-to-back ALU instructions with RUN held: PC_CLK every 4 cycles.
        do_reset();
        IMEM_INST = 32'h00500093; IMEM_RDY = 1'b1; RUN = 1'b1;
        pulses = 0; first_at = 0; second_at = 0;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (PC_CLK) begin
                pulses++;
                if (pulses == 1) first_at = c;
                if (pulses == 2) second_at = c;
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'd3);
        chk("b2b_first_pc_clk", 32'(first_at), 32'd4);
        chk("b2b_spacing", 32'(second_at - first_at), 32'd4);
        RUN = 1'b0;
        found = 0;
        for (int c = 0; c < 8 && found == 0; c++) begin
            step();
            if (STATE == 4'd0) found = 1;
        end
        chk("b2b_stops_idle", 32'(found), 32'd1);
        chk("b2b_retired", RETIRED_CNT, PERF ? 32'd4 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
